rst_seq: RTL and testbench
==========================

# rst_seq

Reset sequencer that generates the active-low reset lines driving the `R` pins of the DFFSR set/reset flip-flops in the datapath. It asserts resets asynchronously and releases them synchronously, after a hold period, in a staggered order across several reset domains. It also supports a software-requested reset and an optional watchdog. It sits directly upstream of every DFFSR-based register bank: one `R_OUT` bit per bank.

## Interface
- `SYNC_STAGES`, 2: depth of the deassertion synchronizer; must be ≥2.
- `HOLD_CYCLES`, 16: cycles all domains stay in reset after synchronized release; must be ≥1.
- `NUM_DOMAINS`, 4: number of reset domains; must be ≥1.
- `STAGGER`, 4: cycles between consecutive domain releases; must be ≥1.
- `WDOG_CYCLES`, 1024: watchdog timeout in cycles (used only with `RST_SEQ_WDOG_EN`).
- `CLK  in  1`: single clock; all state on rising edge.
- `R  in  1`: asynchronous, active-low reset.
- `SW_RST  in  1`: synchronous software reset request, sampled every edge.
- `WDOG_KICK  in  1`: watchdog kick, sampled every edge.
- `R_OUT  out  NUM_DOMAINS`: active-low domain resets, driven straight from flops. Bit 0 releases first.
- `READY  out  1`: high when all domains are released (state RUN).
- `STATE  out  2`: 0=HOLD, 1=RELEASE, 2=RUN; 3 is never driven.
- `WDOG_FLAG  out  1`: sticky; high once a watchdog timeout has fired.

## Operation
- While `R`=0, with no clock required:
  - `R_OUT`=all 0, `READY`=0, `STATE`=HOLD, `WDOG_FLAG`=0.
  - Synchronizer chain, hold counter, stagger counter, domain index and watchdog counter are all cleared.
- Synchronizer: `SYNC_STAGES` flops shift in 1 after `R` rises. The internal `rst_sync` is the last stage.
- HOLD:
  - Counter holds at 0 while `rst_sync`=0 or `SW_RST`=1.
  - Otherwise it increments every edge.
  - On the `HOLD_CYCLES`-th counting edge: `R_OUT[0]`←1, go to RELEASE.
- RELEASE:
  - The stagger counter counts `STAGGER` edges, then releases the next domain.
  - `R_OUT[i]` rises exactly `i*STAGGER` edges after `R_OUT[0]`.
  - One edge after `R_OUT[NUM_DOMAINS-1]` rises: go to RUN, `READY`←1.
  - If `NUM_DOMAINS`=1, RUN follows `R_OUT[0]` by one edge.
- RUN: holding state. Outputs are stable until `SW_RST`, watchdog timeout, or `R`.
- `SW_RST`=1 at an edge, in any state:
  - After that edge: `R_OUT`=all 0, `READY`=0, `STATE`=HOLD, counters cleared.
  - The sequence restarts as from HOLD; `rst_sync` is unaffected.
  - If `SW_RST` is held high, the block stays in HOLD with the counter at 0.
- Released domains never re-assert except via `SW_RST`, watchdog or `R`. `R_OUT` bits are monotonic within one sequence, so no glitches.
- `R` falling mid-sequence aborts immediately and asynchronously to the reset values.

## Timing
- Edge numbering: edge 1 is the first rising `CLK` after `R` rises.
- `rst_sync` goes high after edge `SYNC_STAGES`.
- `R_OUT[0]` rises after edge `SYNC_STAGES+HOLD_CYCLES`. Defaults: 18.
- `R_OUT[i]` rises after edge `SYNC_STAGES+HOLD_CYCLES+i*STAGGER`. Defaults: 22, 26, 30.
- `READY` rises one edge after the last domain. Default: edge 31.
- For `SW_RST` sampled high at edge n:
  - `R_OUT`=0 and `READY`=0 after edge n.
  - `R_OUT[0]` rises after edge n+`HOLD_CYCLES`.
  - `READY` rises after edge n+`HOLD_CYCLES`+(`NUM_DOMAINS`-1)·`STAGGER`+1. Default: n+29.
- Counter widths: `$clog2(param)+1` bits. Counters never wrap; each saturates at its terminal value, then the state advances.

## Configuration
- `RST_SEQ_WDOG_EN` defined:
  - The watchdog counter runs only in RUN. It clears on `WDOG_KICK`=1 and on leaving RUN.
  - If it reaches `WDOG_CYCLES` edges without a kick, that edge acts exactly as `SW_RST`=1 and sets `WDOG_FLAG`←1.
  - `WDOG_FLAG` clears only on `R`=0.
  - Example: RUN entered at edge m with no kicks; the timeout fires at edge m+`WDOG_CYCLES`.
  - `SW_RST` and a timeout on the same edge count as one restart, and `WDOG_FLAG` is still set.
- `RST_SEQ_WDOG_EN` undefined:
  - No watchdog logic; `WDOG_KICK` is ignored and `WDOG_FLAG` is tied 0.
  - Ports remain present.

## Test plan
- Power-up, defaults: `R` low 3 cycles then high. `R_OUT` rises 0001, 0011, 0111, 1111 after edges 18/22/26/30; `READY`=1 after edge 31; `STATE` reads 0→1→2.
- `R` pulsed low mid-RELEASE (edge 24) and asynchronously, between clock edges: `R_OUT`=0000 and `READY`=0 immediately, with no clock. After re-release the sequence repeats with the same edge offsets.
- `SW_RST` single pulse at edge 40 in RUN: `R_OUT`=0000 after edge 40; `R_OUT[0]` rises after edge 56; `READY` rises after edge 69.
- `SW_RST` held high for edges 40–49: stays HOLD with `R_OUT`=0000; `R_OUT[0]` rises after edge 65.
- `RST_SEQ_WDOG_EN`, `WDOG_CYCLES`=8:
  - No kicks after RUN at edge 31: timeout at edge 39, `R_OUT`=0000, `WDOG_FLAG`=1, re-sequence completes with `READY` after edge 68.
  - Kick every 5 cycles: no timeout and `WDOG_FLAG` stays 0.
- Build without `RST_SEQ_WDOG_EN`, `WDOG_KICK` never asserted for 2000 cycles: `READY` stays 1 and `WDOG_FLAG`=0.

Source files
------------

// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq -- reset sequencer for DFFSR-based register banks.
//
// Asserts every domain reset asynchronously when R falls. Once R is back high
// and the release has been synchronized into CLK, all domains are held in
// reset for HOLD_CYCLES edges. They are then released one by one, bit 0 first,
// with STAGGER edges between consecutive domains. A software reset request
// (SW_RST) restarts the sequence from HOLD. An optional watchdog also
// restarts the sequence.
//
// Optional feature: define RST_SEQ_WDOG_EN to build the watchdog. If the
// macro is not defined, WDOG_KICK is ignored and WDOG_FLAG is tied low.
//
// Ports:
//   CLK        in   single clock; all state changes on its rising edge
//   R          in   asynchronous active-low reset
//   SW_RST     in   synchronous software reset request
//   WDOG_KICK  in   watchdog kick (used only with RST_SEQ_WDOG_EN)
//   R_OUT      out  [NUM_DOMAINS] active-low domain resets, driven from flops
//   READY      out  high once every domain is released (state RUN)
//   STATE      out  0=HOLD, 1=RELEASE, 2=RUN
//   WDOG_FLAG  out  sticky watchdog-timeout flag; cleared only by R
// ---------------------------------------------------------------------------
module rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int NUM_DOMAINS = 4,
    parameter int STAGGER     = 4,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                   CLK,
    input  logic                   R,
    input  logic                   SW_RST,
    input  logic                   WDOG_KICK,
    output logic [NUM_DOMAINS-1:0] R_OUT,
    output logic                   READY,
    output logic [1:0]             STATE,
    output logic                   WDOG_FLAG
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int STAG_W = $clog2(STAGGER) + 1;
    localparam int IDX_W  = $clog2(NUM_DOMAINS) + 1;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [HOLD_W-1:0]      hold_q;
    logic [STAG_W-1:0]      stag_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] rout_q;
    logic                   ready_q;

    logic rst_sync;
    logic wdog_fire;
    logic restart_d;

    assign rst_sync  = sync_q[SYNC_STAGES-1];
    // A watchdog timeout behaves exactly like a software reset request; both
    // on the same edge collapse into a single restart.
    assign restart_d = SW_RST | wdog_fire;

`ifdef RST_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;

    logic [WDOG_W-1:0] wdog_q;
    logic              wdog_flag_q;

    // Fires on the WDOG_CYCLES-th consecutive kick-free edge spent in RUN.
    assign wdog_fire = (state_q == ST_RUN) && !WDOG_KICK &&
                       (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            wdog_q      <= '0;
            wdog_flag_q <= 1'b0;
        end else begin
            // Only counts while in RUN; any restart or kick clears it.
            if (state_q != ST_RUN || WDOG_KICK || restart_d) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end
            if (wdog_fire) begin
                wdog_flag_q <= 1'b1;
            end
        end
    end

    assign WDOG_FLAG = wdog_flag_q;
`else
    logic unused_wdog;

    assign wdog_fire   = 1'b0;
    assign WDOG_FLAG   = 1'b0;
    assign unused_wdog = WDOG_KICK ^ (WDOG_CYCLES > 0);
`endif

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q <= ST_HOLD;
            sync_q  <= '0;
            hold_q  <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            rout_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            // The release synchronizer runs independently of restarts.
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};

            if (restart_d) begin
                state_q <= ST_HOLD;
                hold_q  <= '0;
                stag_q  <= '0;
                idx_q   <= '0;
                rout_q  <= '0;
                ready_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_HOLD: begin
                        if (rst_sync) begin
                            if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                                hold_q  <= '0;
                                stag_q  <= '0;
                                idx_q   <= '0;
                                rout_q  <= NUM_DOMAINS'(1);
                                state_q <= ST_RELEASE;
                            end else begin
                                hold_q <= hold_q + HOLD_W'(1);
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (idx_q == IDX_W'(NUM_DOMAINS - 1)) begin
                            // Last domain went out on the previous edge.
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end else if (stag_q == STAG_W'(STAGGER - 1)) begin
                            stag_q <= '0;
                            idx_q  <= idx_q + IDX_W'(1);
                            // Thermometer fill keeps R_OUT monotonic.
                            rout_q <= (rout_q << 1) | NUM_DOMAINS'(1);
                        end else begin
                            stag_q <= stag_q + STAG_W'(1);
                        end
                    end
                    ST_RUN: begin
                        state_q <= ST_RUN;
                    end
                    default: begin
                        state_q <= ST_HOLD;
                        rout_q  <= '0;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign R_OUT = rout_q;
    assign READY = ready_q;
    assign STATE = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq -- directed self-checking bench for rst_seq (default parameters).
// Edge numbers count rising CLK edges after R is released (edge 1 = first).
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rst_seq;

    localparam int ND = 4;
`ifdef RST_SEQ_WDOG_EN
    localparam int WC = 8;
`else
    localparam int WC = 1024;
`endif

    logic          CLK       = 1'b0;
    logic          R         = 1'b0;
    logic          SW_RST    = 1'b0;
    logic          WDOG_KICK = 1'b0;
    logic [ND-1:0] R_OUT;
    logic          READY;
    logic [1:0]    STATE;
    logic          WDOG_FLAG;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_n   = 0;

    rst_seq #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .NUM_DOMAINS(ND),
        .STAGGER    (4),
        .WDOG_CYCLES(WC)
    ) dut (
        .CLK      (CLK),
        .R        (R),
        .SW_RST   (SW_RST),
        .WDOG_KICK(WDOG_KICK),
        .R_OUT    (R_OUT),
        .READY    (READY),
        .STATE    (STATE),
        .WDOG_FLAG(WDOG_FLAG)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s @edge %0d: got %0h exp %0h ok", tag, edge_n, got, exp);
        end else begin
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] rout, input logic rdy,
                           input logic [1:0] st);
        check({tag, ".r_out"}, 32'(R_OUT), 32'(rout));
        check({tag, ".ready"}, 32'(READY), 32'(rdy));
        check({tag, ".state"}, 32'(STATE), 32'(st));
    endtask

    // Advance to just after the given edge number.
    task automatic step_to(input int target);
        while (edge_n < target) begin
            @(posedge CLK);
            edge_n++;
        end
        #1;
    endtask

    // Pulse R low for 3 cycles, check reset values, release on a falling edge.
    task automatic por(input string tag);
        R = 1'b0;
        #1;
        chk_out({tag, ".rst"}, 4'h0, 1'b0, 2'd0);
        check({tag, ".rst.wflag"}, 32'(WDOG_FLAG), 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        R      = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        // Power-up sequence
        por("pu");
        step_to(17); chk_out("pu17", 4'h0, 1'b0, 2'd0);
        step_to(18); chk_out("pu18", 4'h1, 1'b0, 2'd1);
        step_to(21); chk_out("pu21", 4'h1, 1'b0, 2'd1);
        step_to(22); chk_out("pu22", 4'h3, 1'b0, 2'd1);
        step_to(26); chk_out("pu26", 4'h7, 1'b0, 2'd1);
        step_to(30); chk_out("pu30", 4'hf, 1'b0, 2'd1);
        step_to(31); chk_out("pu31", 4'hf, 1'b1, 2'd2);

        // R dropped between edges mid-RELEASE
        por("ab");
        step_to(24); chk_out("ab24", 4'h3, 1'b0, 2'd1);
        #2 R = 1'b0;
        #1 chk_out("ab_async", 4'h0, 1'b0, 2'd0);
        por("re");
        step_to(17); chk_out("re17", 4'h0, 1'b0, 2'd0);
        step_to(18); chk_out("re18", 4'h1, 1'b0, 2'd1);
        step_to(22); chk_out("re22", 4'h3, 1'b0, 2'd1);
        step_to(30); chk_out("re30", 4'hf, 1'b0, 2'd1);
        step_to(31); chk_out("re31", 4'hf, 1'b1, 2'd2);

        // SW_RST single pulse at edge 40 (watchdog kept kicked)
        WDOG_KICK = 1'b1;
        step_to(39); chk_out("sw39", 4'hf, 1'b1, 2'd2);
        SW_RST = 1'b1;
        step_to(40);
        SW_RST = 1'b0;
        chk_out("sw40", 4'h0, 1'b0, 2'd0);
        step_to(55); chk_out("sw55", 4'h0, 1'b0, 2'd0);
        step_to(56); chk_out("sw56", 4'h1, 1'b0, 2'd1);
        step_to(68); chk_out("sw68", 4'hf, 1'b0, 2'd1);
        step_to(69); chk_out("sw69", 4'hf, 1'b1, 2'd2);

        // SW_RST held for edges 40..49
        por("hd");
        step_to(39); chk_out("hd39", 4'hf, 1'b1, 2'd2);
        SW_RST = 1'b1;
        step_to(45); chk_out("hd45", 4'h0, 1'b0, 2'd0);
        step_to(49);
        SW_RST = 1'b0;
        chk_out("hd49", 4'h0, 1'b0, 2'd0);
        step_to(64); chk_out("hd64", 4'h0, 1'b0, 2'd0);
        step_to(65); chk_out("hd65", 4'h1, 1'b0, 2'd1);
        check("hd65.wflag", 32'(WDOG_FLAG), 32'd0);
        WDOG_KICK = 1'b0;

`ifdef RST_SEQ_WDOG_EN
        // Watchdog timeout without kicks
        por("wd");
        step_to(31); chk_out("wd31", 4'hf, 1'b1, 2'd2);
        step_to(38); chk_out("wd38", 4'hf, 1'b1, 2'd2);
        check("wd38.wflag", 32'(WDOG_FLAG), 32'd0);
        step_to(39); chk_out("wd39", 4'h0, 1'b0, 2'd0);
        check("wd39.wflag", 32'(WDOG_FLAG), 32'd1);
        step_to(67); chk_out("wd67", 4'hf, 1'b0, 2'd1);
        step_to(68); chk_out("wd68", 4'hf, 1'b1, 2'd2);
        check("wd68.wflag", 32'(WDOG_FLAG), 32'd1);

        // Kick every 5 edges: no timeout
        por("wk");
        step_to(31); chk_out("wk31", 4'hf, 1'b1, 2'd2);
        for (int k = 1; k <= 20; k++) begin
            step_to(31 + 5 * k - 1);
            WDOG_KICK = 1'b1;
            step_to(31 + 5 * k);
            WDOG_KICK = 1'b0;
        end
        step_to(134); chk_out("wk134", 4'hf, 1'b1, 2'd2);
        check("wk134.wflag", 32'(WDOG_FLAG), 32'd0);
`else
        // No watchdog: 2000 kick-free cycles in RUN
        por("nw");
        step_to(31); chk_out("nw31", 4'hf, 1'b1, 2'd2);
        for (int k = 1; k <= 4; k++) begin
            step_to(31 + 500 * k);
            chk_out("nw_run", 4'hf, 1'b1, 2'd2);
            check("nw_run.wflag", 32'(WDOG_FLAG), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
